// File: rtl/cp1_port_writer.sv
// Queued 68K-style port-write initiator for the PROG CPLD latches (P2_BANK, GSEL).
// Each non-empty-BE command is replayed as setup / strobe / hold around a rising nPORTWEx edge.
module cp1_port_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [18:0] i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  input  logic [1:0]  i_cmd_be,
  output logic [18:0] o_m68k_addr,
  output logic [15:0] o_m68k_data,
  output logic        o_m68k_data_oe,
  output logic        o_nas,
  output logic        o_m68k_rw,
  output logic        o_nportwel,
  output logic        o_nportweu,
  output logic        o_busy,
  output logic        o_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   LP_DEPTH  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   LP_ONE_C  = (PW+1)'(1);
  localparam logic [PW-1:0] LP_ONE_P  = PW'(1);
  localparam logic [7:0]    LP_SETUP  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]    LP_STROBE = 8'(STROBE_CYC - 1);
  localparam logic [7:0]    LP_HOLD   = 8'(HOLD_CYC - 1);

  // IDLE: bus parked, pop | SETUP: addr/data/nAS | STROBE: WE low | HOLD: WE high, bus held
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  logic [18:0]   r_fifo_addr [FIFO_DEPTH];
  logic [15:0]   r_fifo_data [FIFO_DEPTH];
  logic [1:0]    r_fifo_be   [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;

  state_t        r_state, w_next_state;
  logic [7:0]    r_cnt;
  logic [1:0]    r_be;

  logic [18:0]   r_addr;
  logic [15:0]   r_data;
  logic          r_oe, r_nas, r_rw, r_wel, r_weu, r_busy, r_done, r_ready;

  logic          w_push, w_pop, w_start;
  logic [1:0]    w_head_be;
  logic [PW:0]   w_count_next;
  logic          w_nas, w_rw, w_oe, w_wel, w_weu, w_done, w_busy, w_ready;

  assign w_push    = i_cmd_valid && r_ready;
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
  assign w_head_be = r_fifo_be[r_rptr];
  assign w_start   = w_pop && (w_head_be != 2'b00);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + LP_ONE_C;
    else if (!w_push && w_pop)
      w_count_next = r_count - LP_ONE_C;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= i_cmd_addr;
      r_fifo_data[r_wptr] <= i_cmd_data;
      r_fifo_be[r_wptr]   <= i_cmd_be;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LP_ONE_P;
      if (w_pop)  r_rptr <= r_rptr + LP_ONE_P;
      r_count <= w_count_next;
    end
  end

  // state register and per-state down-counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_be    <= 2'b00;
    end else begin
      r_state <= w_next_state;
      if (w_start) r_be <= w_head_be;
      if (w_next_state != r_state) begin
        case (w_next_state)
          ST_SETUP:  r_cnt <= LP_SETUP;
          ST_STROBE: r_cnt <= LP_STROBE;
          ST_HOLD:   r_cnt <= LP_HOLD;
          default:   r_cnt <= 8'd0;
        endcase
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)        w_next_state = ST_SETUP;
      ST_SETUP:  if (r_cnt == 8'd0)  w_next_state = ST_STROBE;
      ST_STROBE: if (r_cnt == 8'd0)  w_next_state = ST_HOLD;
      ST_HOLD:   if (r_cnt == 8'd0)  w_next_state = ST_IDLE;
      default:                       w_next_state = ST_IDLE;
    endcase
  end

  // outputs decoded from the next state so each registered output matches its cycle
  always_comb begin
    w_nas = 1'b1;
    w_rw  = 1'b1;
    w_oe  = 1'b0;
    w_wel = 1'b1;
    w_weu = 1'b1;
    if (w_next_state != ST_IDLE) begin
      w_nas = 1'b0;
      w_rw  = 1'b0;
      w_oe  = 1'b1;
    end
    if (w_next_state == ST_STROBE) begin
      w_wel = !r_be[0];
      w_weu = !r_be[1];
    end
    w_done  = (r_state == ST_HOLD) && (w_next_state == ST_IDLE);
    w_busy  = (w_next_state != ST_IDLE) || (w_count_next != '0);
    w_ready = (w_count_next != LP_DEPTH);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_oe    <= 1'b0;
      r_nas   <= 1'b1;
      r_rw    <= 1'b1;
      r_wel   <= 1'b1;
      r_weu   <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      if (w_start) begin
        r_addr <= r_fifo_addr[r_rptr];
        r_data <= r_fifo_data[r_rptr];
      end
      r_oe    <= w_oe;
      r_nas   <= w_nas;
      r_rw    <= w_rw;
      r_wel   <= w_wel;
      r_weu   <= w_weu;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_ready <= w_ready;
    end
  end

  assign o_cmd_ready    = r_ready;
  assign o_m68k_addr    = r_addr;
  assign o_m68k_data    = r_data;
  assign o_m68k_data_oe = r_oe;
  assign o_nas          = r_nas;
  assign o_m68k_rw      = r_rw;
  assign o_nportwel     = r_wel;
  assign o_nportweu     = r_weu;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_cp1_port_writer.sv
// Scoreboard bench for cp1_port_writer: queued expected bus cycles, decoupled bus monitor.
module tb_cp1_port_writer;
  localparam int S_A = 2, T_A = 3, H_A = 2, D_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_oe, a_nas, a_rw, a_wel, a_weu, a_busy, a_done;
  logic [18:0] a_addr, a_maddr;
  logic [15:0] a_data, a_mdata;
  logic [1:0]  a_be;

  logic        b_valid, b_ready, b_oe, b_nas, b_rw, b_wel, b_weu, b_busy, b_done;
  logic [18:0] b_addr, b_maddr;
  logic [15:0] b_data, b_mdata;
  logic [1:0]  b_be;

  cp1_port_writer #(.SETUP_CYC(S_A), .STROBE_CYC(T_A), .HOLD_CYC(H_A), .FIFO_DEPTH(D_A)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(a_valid), .o_cmd_ready(a_ready),
    .i_cmd_addr(a_addr), .i_cmd_data(a_data), .i_cmd_be(a_be),
    .o_m68k_addr(a_maddr), .o_m68k_data(a_mdata), .o_m68k_data_oe(a_oe),
    .o_nas(a_nas), .o_m68k_rw(a_rw), .o_nportwel(a_wel), .o_nportweu(a_weu),
    .o_busy(a_busy), .o_done(a_done));

  cp1_port_writer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .FIFO_DEPTH(2)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(b_valid), .o_cmd_ready(b_ready),
    .i_cmd_addr(b_addr), .i_cmd_data(b_data), .i_cmd_be(b_be),
    .o_m68k_addr(b_maddr), .o_m68k_data(b_mdata), .o_m68k_data_oe(b_oe),
    .o_nas(b_nas), .o_m68k_rw(b_rw), .o_nportwel(b_wel), .o_nportweu(b_weu),
    .o_busy(b_busy), .o_done(b_done));

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } cmd_t;

  cmd_t exp_q[$];
  int   gap_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: one bus cycle = a run of nAS-low samples; compared against the queue head when it ends.
  int          mon_len, mon_wel, mon_weu, mon_idle;
  logic        mon_in, mon_bad_hold, mon_bad_win;
  logic [18:0] mon_addr;
  logic [15:0] mon_data;
  cmd_t        mon_e;

  initial begin
    mon_in   = 1'b0;
    mon_idle = 1000;
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_in   = 1'b0;
      mon_idle = 1000;
    end else begin
      chk("done_pulse", a_done, mon_in && a_nas);
      if (!a_nas) begin
        if (!mon_in) begin
          mon_in = 1'b1;
          mon_len = 0; mon_wel = 0; mon_weu = 0;
          mon_bad_hold = 1'b0; mon_bad_win = 1'b0;
          mon_addr = a_maddr;
          mon_data = a_mdata;
          gap_q.push_back(mon_idle);
        end
        if (a_maddr != mon_addr || a_mdata != mon_data || !a_oe || a_rw) mon_bad_hold = 1'b1;
        if ((!a_wel || !a_weu) && (mon_len < S_A || mon_len >= S_A + T_A)) mon_bad_win = 1'b1;
        if (!a_wel) mon_wel++;
        if (!a_weu) mon_weu++;
        mon_len++;
      end else begin
        chk("idle_levels", {a_rw, a_oe, a_wel, a_weu}, 4'b1011);
        if (mon_in) begin
          mon_in = 1'b0;
          mon_idle = 1;
          if (exp_q.size() == 0) begin
            timeout_fail("unexpected_bus_cycle");
          end else begin
            mon_e = exp_q.pop_front();
            chk("cyc_addr", mon_addr, mon_e.addr);
            chk("cyc_data", mon_data, mon_e.data);
            chk("cyc_nas_len", mon_len, S_A + T_A + H_A);
            chk("cyc_wel_len", mon_wel, mon_e.be[0] ? T_A : 0);
            chk("cyc_weu_len", mon_weu, mon_e.be[1] ? T_A : 0);
            chk("cyc_bus_stable", mon_bad_hold, 1'b0);
            chk("cyc_strobe_window", mon_bad_win, 1'b0);
          end
        end else begin
          mon_idle++;
        end
      end
    end
  end

  // Starts and ends at a negedge; drives immediately so callers control the push edge.
  task automatic push_a(input logic [18:0] a, input logic [15:0] d, input logic [1:0] b,
                        output int stalls);
    logic acc;
    cmd_t c;
    a_addr = a; a_data = d; a_be = b; a_valid = 1'b1;
    stalls = 0;
    acc = 1'b0;
    forever begin
      acc = a_ready;
      @(posedge clk);
      if (acc) break;
      stalls++;
      if (stalls > 200) begin
        timeout_fail("push_stall");
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      c.addr = a; c.data = d; c.be = b;
      if (b != 2'b00) exp_q.push_back(c);
    end
    #1 a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 || a_busy) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        timeout_fail(name);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while (!a_done) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  initial begin
    int st, guard, nl, wl, dn;
    logic [18:0] seen_addr;
    a_valid = 0; a_addr = '0; a_data = '0; a_be = '0;
    b_valid = 0; b_addr = '0; b_data = '0; b_be = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {a_nas, a_rw, a_wel, a_weu, a_oe}, 5'b11110);
    chk("rst_addr", a_maddr, 0);
    chk("rst_data", a_mdata, 0);
    chk("rst_flags", {a_done, a_busy, a_ready}, 3'b001);
    rst = 1'b0;
    @(negedge clk);

    // single write to GSEL, latency from accept edge
    push_a(19'h607F7, 16'h0005, 2'b01, st);
    chk("lat_first_idle", a_nas, 1'b1);
    chk("busy_after_push", a_busy, 1'b1);
    @(negedge clk);
    chk("lat_nas_low", a_nas, 1'b0);
    wait_idle("single_drain");

    push_a(19'h12345, 16'hA55A, 2'b11, st);
    wait_idle("be11_drain");
    push_a(19'h00F0F, 16'h3C3C, 2'b10, st);
    wait_idle("be10_drain");

    // BE=00 is discarded with no bus activity
    push_a(19'h7FFFF, 16'hFFFF, 2'b00, st);
    chk("be00_busy_queued", a_busy, 1'b1);
    @(negedge clk);
    chk("be00_busy_clear", a_busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("be00_nas_idle", a_nas, 1'b1);

    // back-to-back burst: backpressure and single idle gaps
    gap_q.delete();
    for (int i = 0; i < 5; i++) push_a(19'(32'h100 + i), 16'(32'hB000 + i), 2'(1 + i % 3), st);
    chk("burst_ready_full", a_ready, 1'b0);
    chk("burst_busy", a_busy, 1'b1);
    push_a(19'h00200, 16'hB0B0, 2'b11, st);
    chk("burst_stalled", st > 0, 1'b1);
    wait_idle("burst_drain");
    chk("burst_cycles", gap_q.size(), 6);
    for (int i = 1; i < gap_q.size(); i++) chk("burst_gap", gap_q[i], 1);

    // push on the same edge as a pop with three entries held
    for (int i = 0; i < 4; i++) push_a(19'(32'h300 + i), 16'(32'hC000 + i), 2'b01, st);
    wait_done("same_edge_done");
    push_a(19'h00399, 16'hCCCC, 2'b10, st);
    chk("same_edge_ready", a_ready, 1'b1);
    push_a(19'h0039A, 16'hCDCD, 2'b11, st);
    chk("same_edge_full", a_ready, 1'b0);
    wait_idle("same_edge_drain");

    // reset in the second strobe cycle with two entries queued
    for (int i = 0; i < 3; i++) push_a(19'(32'h400 + i), 16'(32'hD000 + i), 2'b11, st);
    guard = 0;
    while (a_wel && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) timeout_fail("reset_wait_strobe");
    @(posedge clk);
    #1;
    chk("pre_reset_strobe", a_wel, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_bus", {a_nas, a_rw, a_wel, a_weu, a_oe}, 5'b11110);
    chk("mid_rst_addr", a_maddr, 0);
    chk("mid_rst_data", a_mdata, 0);
    chk("mid_rst_flags", {a_done, a_busy, a_ready}, 3'b001);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_flags", {a_nas, a_busy, a_ready}, 3'b101);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      push_a(19'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), st);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle("random_drain");

    // minimal timing instance
    b_addr = 19'h2AAAA; b_data = 16'h1234; b_be = 2'b01; b_valid = 1'b1;
    @(posedge clk);
    #1 b_valid = 1'b0;
    nl = 0; wl = 0; dn = 0; seen_addr = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (!b_nas) begin
        nl++;
        seen_addr = b_maddr;
      end
      if (!b_wel) wl++;
      if (b_done) dn++;
    end
    chk("min_nas_len", nl, 3);
    chk("min_strobe_len", wl, 1);
    chk("min_done_count", dn, 1);
    chk("min_addr", seen_addr, 19'h2AAAA);
    chk("min_busy_end", b_busy, 1'b0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
